// File: rtl/cache_mem_arb_pkg.sv
// Shared types and widths for the cache/memory request arbiter.
// Fixes the memory request layout and the per-source transaction ID format.
package cache_mem_arb_pkg;

  localparam int MEM_ADDR_W   = 64;
  localparam int MEM_DATA_W   = 64;
  localparam int MEM_SRC_ID_W = 1;
  localparam int TID_W        = MEM_SRC_ID_W + 1;
  localparam int CNT_W        = 3;

  typedef enum logic {
    SRC_IC = 1'b0,
    SRC_DC = 1'b1
  } src_e;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic                  we;
    logic [MEM_DATA_W-1:0] wdata;
    logic [1:0]            size;
    logic [TID_W-1:0]      tid;
  } mem_req_t;

endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter with a one-hot grant.
// After a grant the pointer moves to the other requester; reset favours the data cache.
module rr_arb2
  import cache_mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] elig,
  input  logic       en,
  output logic [1:0] gnt
);

  src_e ptr_q;

  assign gnt[SRC_IC] = en & elig[SRC_IC] & ((ptr_q == SRC_IC) | ~elig[SRC_DC]);
  assign gnt[SRC_DC] = en & elig[SRC_DC] & ((ptr_q == SRC_DC) | ~elig[SRC_IC]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= SRC_DC;
    end else if (gnt[SRC_IC]) begin
      ptr_q <= SRC_DC;
    end else if (gnt[SRC_DC]) begin
      ptr_q <= SRC_IC;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory request channel between the I-cache refill path and the D-cache.
// One-entry registered request slot, per-source outstanding limits, response routing by tid.
module cache_mem_arbiter
  import cache_mem_arb_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int SRC_ID_W = MEM_SRC_ID_W,
  parameter int MAX_OUT  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ic_req_i,
  output logic                  ic_gnt_o,
  input  logic [ADDR_W-1:0]     ic_addr_i,
  input  logic [SRC_ID_W-1:0]   ic_id_i,
  input  logic                  dc_req_i,
  output logic                  dc_gnt_o,
  input  logic [ADDR_W-1:0]     dc_addr_i,
  input  logic                  dc_we_i,
  input  logic [DATA_W-1:0]     dc_wdata_i,
  input  logic [1:0]            dc_size_i,
  input  logic [SRC_ID_W-1:0]   dc_id_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output mem_req_t              mem_req_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [SRC_ID_W:0]     mem_rsp_tid_i,
  output logic                  ic_rsp_valid_o,
  output logic                  dc_rsp_valid_o,
  output logic [SRC_ID_W-1:0]   rsp_id_o,
  input  logic                  drain_i,
  output logic                  idle_o
);

  logic [1:0] req;
  logic [1:0] elig;
  logic [1:0] gnt;
  logic [1:0] rsp_hit;
  logic [1:0] cnt_zero;
  logic       slot_free;
  mem_req_t   slot_d;
  mem_req_t   slot_q;
  logic       valid_q;

  assign req[SRC_IC] = ic_req_i;
  assign req[SRC_DC] = dc_req_i;

  // The slot can take a new request when empty or when it is handing off this cycle.
  assign slot_free = ~valid_q | mem_req_ready_i;

  rr_arb2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .elig  (elig),
    .en    (slot_free),
    .gnt   (gnt)
  );

  assign ic_gnt_o = gnt[SRC_IC];
  assign dc_gnt_o = gnt[SRC_DC];

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    slot_d = '0;
    if (gnt[SRC_DC]) begin
      slot_d.addr  = dc_addr_i;
      slot_d.we    = dc_we_i;
      slot_d.wdata = dc_wdata_i;
      slot_d.size  = dc_size_i;
      slot_d.tid   = {1'b1, dc_id_i};
    end else begin
      slot_d.addr  = ic_addr_i;
      slot_d.size  = 2'd3;
      slot_d.tid   = {1'b0, ic_id_i};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      slot_q  <= '0;
    end else if (|gnt) begin
      valid_q <= 1'b1;
      slot_q  <= slot_d;
    end else if (mem_req_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign mem_req_valid_o = valid_q;
  assign mem_req_o       = slot_q;

  assign ic_rsp_valid_o  = mem_rsp_valid_i & ~mem_rsp_tid_i[SRC_ID_W];
  assign dc_rsp_valid_o  = mem_rsp_valid_i &  mem_rsp_tid_i[SRC_ID_W];
  assign rsp_id_o        = mem_rsp_tid_i[SRC_ID_W-1:0];

  assign rsp_hit[SRC_IC] = ic_rsp_valid_o;
  assign rsp_hit[SRC_DC] = dc_rsp_valid_o;

  for (genvar s = 0; s < 2; s++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic             dec;

    // A response against an empty count is dropped so the counter never wraps.
    assign dec         = rsp_hit[s] & (cnt_q != '0);
    assign cnt_zero[s] = (cnt_q == '0);
    assign elig[s]     = req[s] & (cnt_q < CNT_W'(MAX_OUT)) & ~drain_i;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q <= '0;
      end else if (gnt[s] & ~dec) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (dec & ~gnt[s]) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end

    rsp_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(rsp_hit[s] && cnt_zero[s]));
  end

  assign idle_o = ~valid_q & (&cnt_zero);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios then random traffic,
// all compared each cycle against a transaction-level model of the arbitration rules.
module tb_cache_mem_arbiter;
  import cache_mem_arb_pkg::*;

  localparam int MAX_OUT = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    ic_req, ic_gnt, dc_req, dc_gnt;
  logic [MEM_ADDR_W-1:0]   ic_addr, dc_addr;
  logic [MEM_SRC_ID_W-1:0] ic_id, dc_id, rsp_id;
  logic                    dc_we;
  logic [MEM_DATA_W-1:0]   dc_wdata;
  logic [1:0]              dc_size;
  logic                    mem_req_valid, ready;
  mem_req_t                mem_req;
  logic                    rsp_valid;
  logic [TID_W-1:0]        rsp_tid;
  logic                    ic_rsp_valid, dc_rsp_valid;
  logic                    drain, idle;

  int tests = 0;
  int fails = 0;

  // Reference model: outstanding counts, slot occupancy, favoured source.
  int               m_cnt [2];
  bit               m_full;
  mem_req_t         m_slot;
  int               m_fav;
  logic [TID_W-1:0] pend_q [$];
  int               pick;

  cache_mem_arbiter #(.MAX_OUT(MAX_OUT)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ic_req_i        (ic_req),
    .ic_gnt_o        (ic_gnt),
    .ic_addr_i       (ic_addr),
    .ic_id_i         (ic_id),
    .dc_req_i        (dc_req),
    .dc_gnt_o        (dc_gnt),
    .dc_addr_i       (dc_addr),
    .dc_we_i         (dc_we),
    .dc_wdata_i      (dc_wdata),
    .dc_size_i       (dc_size),
    .dc_id_i         (dc_id),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_ready_i (ready),
    .mem_req_o       (mem_req),
    .mem_rsp_valid_i (rsp_valid),
    .mem_rsp_tid_i   (rsp_tid),
    .ic_rsp_valid_o  (ic_rsp_valid),
    .dc_rsp_valid_o  (dc_rsp_valid),
    .rsp_id_o        (rsp_id),
    .drain_i         (drain),
    .idle_o          (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_full   = 1'b0;
    m_slot   = '0;
    m_fav    = 1;
    pend_q.delete();
  endtask

  task automatic send_rsp(input int idx);
    rsp_valid = 1'b1;
    rsp_tid   = pend_q[idx];
    pend_q.delete(idx);
  endtask

  // Called at posedge+1 with inputs applied; checks mid-cycle, advances the model, returns at next posedge+1.
  task automatic step();
    int       w;
    int       rs;
    bit       room, dec;
    bit       el [2];
    mem_req_t nxt;
    #3;
    el[0] = ic_req && (m_cnt[0] < MAX_OUT) && !drain;
    el[1] = dc_req && (m_cnt[1] < MAX_OUT) && !drain;
    room  = !m_full || ready;
    w     = -1;
    if (room) begin
      if (el[0] && el[1]) w = m_fav;
      else if (el[1])     w = 1;
      else if (el[0])     w = 0;
    end
    check("ic_gnt", ic_gnt, w == 0);
    check("dc_gnt", dc_gnt, w == 1);
    check("req_valid", mem_req_valid, m_full);
    if (m_full) check("req_data", mem_req, m_slot);
    check("idle", idle, !m_full && m_cnt[0] == 0 && m_cnt[1] == 0);
    check("ic_rsp", ic_rsp_valid, rsp_valid && !rsp_tid[TID_W-1]);
    check("dc_rsp", dc_rsp_valid, rsp_valid && rsp_tid[TID_W-1]);
    check("rsp_id", rsp_id, rsp_tid[MEM_SRC_ID_W-1:0]);
    if (rst) begin
      model_clear();
    end else begin
      if (m_full && ready) pend_q.push_back(m_slot.tid);
      rs  = rsp_tid[TID_W-1] ? 1 : 0;
      dec = rsp_valid && (m_cnt[rs] > 0);
      if (w >= 0) begin
        nxt = '0;
        if (w == 1) begin
          nxt.addr  = dc_addr;
          nxt.we    = dc_we;
          nxt.wdata = dc_wdata;
          nxt.size  = dc_size;
          nxt.tid   = {1'b1, dc_id};
        end else begin
          nxt.addr  = ic_addr;
          nxt.size  = 2'd3;
          nxt.tid   = {1'b0, ic_id};
        end
        m_slot = nxt;
        m_full = 1'b1;
        m_cnt[w]++;
        m_fav = 1 - w;
      end else if (ready) begin
        m_full = 1'b0;
      end
      if (dec) m_cnt[rs]--;
    end
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    ic_req = 1'b0;
    dc_req = 1'b0;
    drain  = 1'b0;
    step();
    rst    = 1'b0;
  endtask

  task automatic settle();
    ic_req = 1'b0;
    dc_req = 1'b0;
    drain  = 1'b0;
    ready  = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (!m_full && pend_q.size() == 0 && m_cnt[0] == 0 && m_cnt[1] == 0) break;
      if (pend_q.size() > 0) send_rsp(0);
      step();
    end
    check("settle_idle", idle, 1'b1);
  endtask

  initial begin
    rst = 1'b1; ic_req = 1'b0; dc_req = 1'b0; drain = 1'b0; ready = 1'b0;
    rsp_valid = 1'b0; rsp_tid = '0;
    ic_addr = 64'h1000; ic_id = '0;
    dc_addr = 64'h2000; dc_id = '0; dc_we = 1'b1; dc_wdata = 64'hdead_beef_0123_4567; dc_size = 2'd2;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_valid", mem_req_valid, 1'b0);
    check("reset_req", mem_req, '0);
    check("reset_idle", idle, 1'b1);
    check("reset_gnt", {ic_gnt, dc_gnt}, 2'b00);

    // Concurrent requests alternate DC, IC, DC, IC.
    ic_req = 1'b1; dc_req = 1'b1; ready = 1'b1;
    repeat (5) step();
    settle();

    // Data cache alone hits the outstanding limit, then resumes after one response.
    do_reset();
    dc_req = 1'b1; ready = 1'b1;
    repeat (5) step();
    send_rsp(0);
    step();
    step();
    settle();

    // Back-pressure holds the slot stable; release gives a back-to-back grant.
    do_reset();
    ic_req = 1'b1; ready = 1'b0;
    repeat (6) step();
    ready = 1'b1;
    step();
    ic_req = 1'b0;
    step();
    settle();

    // Response routing by tid, and grant plus response on one source.
    do_reset();
    dc_req = 1'b1; dc_id = 1'b1; ic_req = 1'b1; ic_id = 1'b1; ready = 1'b1;
    step();
    step();
    ic_req = 1'b0; dc_req = 1'b0;
    step();
    step();
    send_rsp(0);
    step();
    send_rsp(0);
    step();
    dc_req = 1'b1; dc_id = 1'b0;
    step();
    step();
    send_rsp(0);
    step();
    dc_req = 1'b0;
    step();
    settle();

    // Drain with one held request and two outstanding.
    do_reset();
    dc_req = 1'b1; ready = 1'b1;
    step();
    step();
    ready = 1'b0; drain = 1'b1;
    repeat (3) step();
    ready = 1'b1;
    step();
    step();
    send_rsp(0);
    step();
    send_rsp(0);
    step();
    check("drain_idle", idle, 1'b1);
    dc_req = 1'b0; drain = 1'b0;
    step();

    // Reset with the slot full and counts 2/1.
    ic_req = 1'b1; dc_req = 1'b1; ready = 1'b1;
    repeat (3) step();
    ic_req = 1'b0; dc_req = 1'b0; ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_valid", mem_req_valid, 1'b0);
    check("rst_mid_req", mem_req, '0);
    check("rst_mid_idle", idle, 1'b1);
    ic_req = 1'b1; dc_req = 1'b1; ready = 1'b1;
    step();
    settle();

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      ic_req   = ($urandom_range(0, 9) < 7);
      ic_addr  = {$urandom(), $urandom()};
      ic_id    = MEM_SRC_ID_W'($urandom());
      dc_req   = ($urandom_range(0, 9) < 7);
      dc_addr  = {$urandom(), $urandom()};
      dc_we    = 1'($urandom());
      dc_wdata = {$urandom(), $urandom()};
      dc_size  = 2'($urandom());
      dc_id    = MEM_SRC_ID_W'($urandom());
      ready    = ($urandom_range(0, 9) < 6);
      drain    = ($urandom_range(0, 9) == 0);
      if (pend_q.size() > 0 && $urandom_range(0, 9) < 5) begin
        pick = $urandom_range(0, pend_q.size() - 1);
        send_rsp(pick);
      end
      step();
    end
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
